score_bcd_sequencer: RTL and testbench

//  Frame-synchronous sequential binary-to-BCD converter for the on-screen score.

---
 rtl/score_bcd_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_score_bcd_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_sequencer.sv
// -----------------------------------------------------------------------------
// score_bcd_sequencer
//
// Purpose:
//   Converts the binary game score to three BCD digits once per frame. The
//   conversion runs as a sequential double-dabble, one shift per clock. The
//   finished digits and their sprite-strip x offsets are then published as
//   registered values, so the renderer never sees a digit change mid-frame.
//
// Ports:
//   clk            in   system/pixel clock (only clock)
//   resetn         in   asynchronous active-low reset, released synchronously
//   score          in   [SCORE_WIDTH-1:0] unsigned binary score; may change on any cycle
//   frame_start    in   one-cycle pulse at the start of vertical blanking
//   busy           out  a conversion is in progress
//   digits_valid   out  one-cycle strobe when new digits are published
//   saturated      out  the last published score was clamped to MAX_SCORE
//   hundreds/tens/ones              out [3:0] published BCD digits
//   off_hundreds/off_tens/off_ones  out [9:0] NUM_WIDTH*digit, registered
//   show_hundreds/show_tens         out digit-enable flags for the renderer
//
// Handshake:
//   frame_start is a fire-and-forget request. It is accepted only in IDLE.
//   A request that arrives while busy is dropped and is not queued.
//   digits_valid is a strobe with no back-pressure. Every published output
//   holds its value until the next digits_valid strobe.
//
// Configuration macro: SCORE_ZERO_BLANK_EN
//   defined   -> leading zeros are blanked. show_hundreds and show_tens are
//                registered at LATCH and reset to 0.
//   undefined -> show_hundreds and show_tens are tied to 1.
//
// Debug: the FSM state is held in state_q (type state_e), so a checker can
//   bind to it hierarchically.
// -----------------------------------------------------------------------------
module score_bcd_sequencer #(
  parameter int SCORE_WIDTH = 32,
  parameter int NUM_WIDTH   = 34,
  parameter int MAX_SCORE   = 999
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [SCORE_WIDTH-1:0] score,
  input  logic                   frame_start,
  output logic                   busy,
  output logic                   digits_valid,
  output logic                   saturated,
  output logic [3:0]             hundreds,
  output logic [3:0]             tens,
  output logic [3:0]             ones,
  output logic [9:0]             off_hundreds,
  output logic [9:0]             off_tens,
  output logic [9:0]             off_ones,
  output logic                   show_hundreds,
  output logic                   show_tens
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  localparam logic [SCORE_WIDTH-1:0] MAX_WIDE = SCORE_WIDTH'(MAX_SCORE);
  localparam logic [9:0]             MAX_10   = 10'(MAX_SCORE);
  localparam logic [9:0]             NUM_W10  = 10'(NUM_WIDTH);
  localparam logic [3:0]             LAST_CNT = 4'd9;

  state_e      state_q, state_d;
  logic [9:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sat_q, sat_d;

  logic [3:0]  hundreds_q, hundreds_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [9:0]  off_h_q, off_h_d;
  logic [9:0]  off_t_q, off_t_d;
  logic [9:0]  off_o_q, off_o_d;
  logic        saturated_q, saturated_d;
  logic        digits_valid_q, digits_valid_d;
`ifdef SCORE_ZERO_BLANK_EN
  logic        show_h_q, show_h_d;
  logic        show_t_q, show_t_d;
`endif

  // The compare uses the full input width, so large scores clamp correctly.
  logic        score_over;
  logic [9:0]  score_sat;
  logic [11:0] bcd_adj;

  assign score_over = (score > MAX_WIDE);
  assign score_sat  = score_over ? MAX_10 : score[9:0];

  // Double-dabble correction: add 3 to any nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    bin_d          = bin_q;
    bcd_d          = bcd_q;
    cnt_d          = cnt_q;
    sat_d          = sat_q;
    hundreds_d     = hundreds_q;
    tens_d         = tens_q;
    ones_d         = ones_q;
    off_h_d        = off_h_q;
    off_t_d        = off_t_q;
    off_o_d        = off_o_q;
    saturated_d    = saturated_q;
    digits_valid_d = 1'b0;
`ifdef SCORE_ZERO_BLANK_EN
    show_h_d       = show_h_q;
    show_t_d       = show_t_q;
`endif

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          bin_d   = score_sat;
          bcd_d   = 12'd0;
          sat_d   = score_over;
          cnt_d   = 4'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj[10:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 4'd1;
        // cnt_q == 9 means this edge performs the tenth and final shift.
        if (cnt_q == LAST_CNT) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        hundreds_d     = bcd_q[11:8];
        tens_d         = bcd_q[7:4];
        ones_d         = bcd_q[3:0];
        off_h_d        = 10'(bcd_q[11:8]) * NUM_W10;
        off_t_d        = 10'(bcd_q[7:4])  * NUM_W10;
        off_o_d        = 10'(bcd_q[3:0])  * NUM_W10;
        saturated_d    = sat_q;
        digits_valid_d = 1'b1;
`ifdef SCORE_ZERO_BLANK_EN
        show_h_d       = (bcd_q[11:8] != 4'd0);
        show_t_d       = (bcd_q[11:8] != 4'd0) || (bcd_q[7:4] != 4'd0);
`endif
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      bin_q          <= 10'd0;
      bcd_q          <= 12'd0;
      cnt_q          <= 4'd0;
      sat_q          <= 1'b0;
      hundreds_q     <= 4'd0;
      tens_q         <= 4'd0;
      ones_q         <= 4'd0;
      off_h_q        <= 10'd0;
      off_t_q        <= 10'd0;
      off_o_q        <= 10'd0;
      saturated_q    <= 1'b0;
      digits_valid_q <= 1'b0;
`ifdef SCORE_ZERO_BLANK_EN
      show_h_q       <= 1'b0;
      show_t_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      bin_q          <= bin_d;
      bcd_q          <= bcd_d;
      cnt_q          <= cnt_d;
      sat_q          <= sat_d;
      hundreds_q     <= hundreds_d;
      tens_q         <= tens_d;
      ones_q         <= ones_d;
      off_h_q        <= off_h_d;
      off_t_q        <= off_t_d;
      off_o_q        <= off_o_d;
      saturated_q    <= saturated_d;
      digits_valid_q <= digits_valid_d;
`ifdef SCORE_ZERO_BLANK_EN
      show_h_q       <= show_h_d;
      show_t_q       <= show_t_d;
`endif
    end
  end

  // busy covers SHIFT and LATCH: the 11 cycles that follow the accepting edge.
  assign busy         = (state_q != IDLE);
  assign digits_valid = digits_valid_q;
  assign saturated    = saturated_q;
  assign hundreds     = hundreds_q;
  assign tens         = tens_q;
  assign ones         = ones_q;
  assign off_hundreds = off_h_q;
  assign off_tens     = off_t_q;
  assign off_ones     = off_o_q;
`ifdef SCORE_ZERO_BLANK_EN
  assign show_hundreds = show_h_q;
  assign show_tens     = show_t_q;
`else
  assign show_hundreds = 1'b1;
  assign show_tens     = 1'b1;
`endif

endmodule

// File: tb/tb_score_bcd_sequencer.sv
module tb_score_bcd_sequencer;

`ifdef SCORE_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic [31:0] score;
  logic        frame_start;
  logic        busy;
  logic        digits_valid;
  logic        saturated;
  logic [3:0]  hundreds, tens, ones;
  logic [9:0]  off_hundreds, off_tens, off_ones;
  logic        show_hundreds, show_tens;

  int n_cmp  = 0;
  int n_fail = 0;
  int valid_cnt = 0;

  // Scoreboard of expected published values for the current frame:
  // {hundreds, tens, ones, off_h, off_t, off_o, saturated}.
  logic [31:0] exp_q[$];

  score_bcd_sequencer #(
    .SCORE_WIDTH(32),
    .NUM_WIDTH  (34),
    .MAX_SCORE  (999)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .score        (score),
    .frame_start  (frame_start),
    .busy         (busy),
    .digits_valid (digits_valid),
    .saturated    (saturated),
    .hundreds     (hundreds),
    .tens         (tens),
    .ones         (ones),
    .off_hundreds (off_hundreds),
    .off_tens     (off_tens),
    .off_ones     (off_ones),
    .show_hundreds(show_hundreds),
    .show_tens    (show_tens)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Counts every digits_valid pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (digits_valid === 1'b1) valid_cnt++;
  end

  // ---------------- checks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Loads the scoreboard with hand-computed values for one frame.
  task automatic push_exp(input int h, input int t, input int o,
                          input int oh, input int ot, input int oo, input int sat);
    exp_q.push_back(32'(h));  exp_q.push_back(32'(t));  exp_q.push_back(32'(o));
    exp_q.push_back(32'(oh)); exp_q.push_back(32'(ot)); exp_q.push_back(32'(oo));
    exp_q.push_back(32'(sat));
  endtask

  // Compares the published outputs against the scoreboard. exp_show_h and
  // exp_show_t are the flags this build should show.
  task automatic check_pub(input string tag, input logic exp_show_h, input logic exp_show_t);
    check({tag, ".hundreds"},  32'(hundreds),      exp_q.pop_front());
    check({tag, ".tens"},      32'(tens),          exp_q.pop_front());
    check({tag, ".ones"},      32'(ones),          exp_q.pop_front());
    check({tag, ".off_h"},     32'(off_hundreds),  exp_q.pop_front());
    check({tag, ".off_t"},     32'(off_tens),      exp_q.pop_front());
    check({tag, ".off_o"},     32'(off_ones),      exp_q.pop_front());
    check({tag, ".saturated"}, 32'(saturated),     exp_q.pop_front());
    check({tag, ".show_h"},    32'(show_hundreds), 32'(exp_show_h));
    check({tag, ".show_t"},    32'(show_tens),     32'(exp_show_t));
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    resetn      = 1'b0;
    frame_start = 1'b0;
    score       = 32'd0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Drives frame_start for one cycle (sampled at edge N) and returns at the
  // falling edge that follows edge N.
  task automatic pulse_frame(input logic [31:0] s);
    score       = s;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Counts busy cycles until digits_valid shows up, with a cycle budget.
  // Returns at the falling edge on which digits_valid is high.
  task automatic wait_valid(input string tag, output int busy_cycles);
    bit seen = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (digits_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    check({tag, ".valid_seen"}, 32'(seen), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bc;
    int base;

    // 1: reset, then 50 idle clocks.
    apply_reset();
    repeat (50) @(negedge clk);
    check("t1.busy",      32'(busy),      32'd0);
    check("t1.valid_cnt", 32'(valid_cnt), 32'd0);
    push_exp(0, 0, 0, 0, 0, 0, 0);
    check_pub("t1", !BLANK_EN, !BLANK_EN);

    // 2: score 527 -> 5,2,7 with offsets 170,68,238; busy for 11 cycles.
    base = valid_cnt;
    pulse_frame(32'd527);
    check("t2.busy_after_start", 32'(busy), 32'd1);
    wait_valid("t2", bc);
    check("t2.busy_cycles", 32'(bc), 32'd11);
    check("t2.busy_at_valid", 32'(busy), 32'd0);
    push_exp(5, 2, 7, 170, 68, 238, 0);
    check_pub("t2", 1'b1, 1'b1);
    @(negedge clk);
    check("t2.valid_one_cycle", 32'(digits_valid), 32'd0);
    repeat (10) @(negedge clk);
    check("t2.valid_pulses", 32'(valid_cnt - base), 32'd1);
    push_exp(5, 2, 7, 170, 68, 238, 0);
    check_pub("t2.hold", 1'b1, 1'b1);

    // 3: 1234 saturates to 999; an exact 999 is not saturated.
    pulse_frame(32'd1234);
    wait_valid("t3a", bc);
    push_exp(9, 9, 9, 306, 306, 306, 1);
    check_pub("t3a", 1'b1, 1'b1);
    @(negedge clk);
    pulse_frame(32'd999);
    wait_valid("t3b", bc);
    push_exp(9, 9, 9, 306, 306, 306, 0);
    check_pub("t3b", 1'b1, 1'b1);
    // A value above 10 bits that wraps to a small number must still clamp.
    @(negedge clk);
    pulse_frame(32'h8000_0005);
    wait_valid("t3c", bc);
    push_exp(9, 9, 9, 306, 306, 306, 1);
    check_pub("t3c", 1'b1, 1'b1);

    // 4: a second frame_start 4 clocks in is ignored; the score change is ignored.
    @(negedge clk);
    base = valid_cnt;
    pulse_frame(32'd123);
    repeat (2) @(negedge clk);
    pulse_frame(32'd456);
    wait_valid("t4", bc);
    push_exp(1, 2, 3, 34, 68, 102, 0);
    check_pub("t4", 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("t4.valid_pulses", 32'(valid_cnt - base), 32'd1);
    check("t4.busy_after", 32'(busy), 32'd0);

    // 5: score 7 -> leading zeros blanked only in the blanking build.
    pulse_frame(32'd7);
    wait_valid("t5", bc);
    push_exp(0, 0, 7, 0, 0, 238, 0);
    check_pub("t5", !BLANK_EN, !BLANK_EN);

    // 6: reset in the middle of SHIFT (cnt=5), then convert normally.
    @(negedge clk);
    base = valid_cnt;
    pulse_frame(32'd321);
    repeat (5) @(negedge clk);
    check("t6.busy_before_rst", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    check("t6.busy_in_rst",  32'(busy),         32'd0);
    check("t6.valid_in_rst", 32'(digits_valid), 32'd0);
    push_exp(0, 0, 0, 0, 0, 0, 0);
    check_pub("t6.rst", !BLANK_EN, !BLANK_EN);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    check("t6.no_pulse", 32'(valid_cnt - base), 32'd0);
    pulse_frame(32'd88);
    wait_valid("t6.after", bc);
    check("t6.busy_cycles", 32'(bc), 32'd11);
    push_exp(0, 8, 8, 0, 272, 272, 0);
    check_pub("t6.after", !BLANK_EN, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
